// File: rtl/host_bus_arbiter_pkg.sv
// host_bus_arbiter_pkg: shared FSM state enum and host-bus rw encodings
package host_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_CLEAR} state_e;
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;
endpackage

// File: rtl/host_bus_arbiter_picker.sv
// rr_priority_picker: pick lowest set request at or above i_ptr, else lowest overall
// Ports: i_req (request vector), i_ptr (search start index), o_grant (one-hot), o_valid (any request)
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);
  logic [NUM_REQ-1:0] w_hi, w_src;
  // requests at index >= pointer win first; otherwise the search wraps to index 0
  assign w_hi    = i_req & ~((NUM_REQ'(1) << i_ptr) - NUM_REQ'(1));
  assign w_src   = |w_hi ? w_hi : i_req;
  assign o_grant = w_src & (~w_src + NUM_REQ'(1));
  assign o_valid = |i_req;
endmodule

// File: rtl/host_bus_arbiter.sv
// host_bus_arbiter: arbitrates NUM_REQ requesters onto one simple_axi_master host bus
// Requester side: i_req/i_req_rw/i_req_addr/i_req_wdata in; o_req_done/o_req_err/o_rdata/o_grant out.
// Master side: o_addr/o_wdata/o_rw/o_clear_done out; i_rdata/i_wait/i_done/i_invalid/i_error in.
// Define HOST_BUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module host_bus_arbiter
  import host_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_done,
  output logic                          o_req_err,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic [1:0]                    o_rw,
  output logic                          o_clear_done,
  input  logic [DATA_WIDTH-1:0]         i_rdata,
  input  logic                          i_wait,
  input  logic                          i_done,
  input  logic                          i_invalid,
  input  logic                          i_error
);
  localparam int IDX_W = $clog2(NUM_REQ);
  state_e                  r_state, w_next;
  logic [NUM_REQ-1:0]      r_grant, w_elig, w_pick;
  logic                    w_valid, w_latch, w_active, w_unused_wait;
  logic [1:0]              r_rw, w_sel_rw;
  logic [ADDR_WIDTH-1:0]   r_addr, w_sel_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, w_sel_wdata, r_rdata;
  logic                    r_err;
  logic [IDX_W-1:0]        w_ptr;
  // the master's busy flag is informational; completion is signalled by i_done alone
  assign w_unused_wait = i_wait;
  always_comb begin
    w_elig      = '0;
    w_sel_rw    = RW_IDLE;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_elig[k]   = i_req[k] && (i_req_rw[2*k +: 2] != RW_IDLE);
      w_sel_rw    = w_sel_rw | ({2{w_pick[k]}} & i_req_rw[2*k +: 2]);
      w_sel_addr  = w_sel_addr | ({ADDR_WIDTH{w_pick[k]}} & i_req_addr[ADDR_WIDTH*k +: ADDR_WIDTH]);
      w_sel_wdata = w_sel_wdata | ({DATA_WIDTH{w_pick[k]}} & i_req_wdata[DATA_WIDTH*k +: DATA_WIDTH]);
    end
  end
  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req   (w_elig),
    .i_ptr   (w_ptr),
    .o_grant (w_pick),
    .o_valid (w_valid)
  );
  assign w_latch = (r_state == ST_IDLE) && w_valid;
`ifdef HOST_BUS_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr, w_win_idx;
  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_pick[k]) w_win_idx = IDX_W'(k);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_ptr <= '0;
    else if (w_latch) r_ptr <= (w_win_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;
  assign w_ptr = r_ptr;
`endif
  // rw=11 is granted but skips the master entirely and completes with an error
  always_comb begin
    w_next = r_state == ST_IDLE      ? (w_valid ? (w_sel_rw == RW_BOTH ? ST_CLEAR : ST_ISSUE) : ST_IDLE)
           : r_state == ST_ISSUE     ? ST_WAIT_DONE
           : r_state == ST_WAIT_DONE ? (i_done ? ST_CLEAR : ST_WAIT_DONE)
           : ST_IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant <= '0;
      r_rw    <= RW_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_grant <= w_pick;
        r_rw    <= w_sel_rw;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_rdata <= '0;
        r_err   <= (w_sel_rw == RW_BOTH);
      end
      if (r_state == ST_WAIT_DONE && i_done) begin
        r_rdata <= i_rdata;
        r_err   <= i_error | i_invalid;
      end
      if (r_state == ST_CLEAR) r_grant <= '0;
    end
  end
  assign w_active     = (r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE);
  assign o_grant      = r_grant;
  assign o_rw         = w_active ? r_rw : RW_IDLE;
  assign o_addr       = w_active ? r_addr : '0;
  assign o_wdata      = w_active ? r_wdata : '0;
  assign o_clear_done = (r_state == ST_CLEAR) && (r_rw != RW_BOTH);
  assign o_req_done   = (r_state == ST_CLEAR) ? r_grant : '0;
  assign o_rdata      = (r_state == ST_CLEAR) ? r_rdata : '0;
  assign o_req_err    = (r_state == ST_CLEAR) && r_err;
endmodule

// File: tb/tb_host_bus_arbiter.sv
// tb_host_bus_arbiter: directed self-checking bench for host_bus_arbiter
module tb_host_bus_arbiter;
  localparam int N = 4;
`ifdef HOST_BUS_ARB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [N-1:0]  i_req = '0;
  logic [2*N-1:0] i_req_rw = '0;
  logic [N*32-1:0] i_req_addr = '0;
  logic [N*32-1:0] i_req_wdata = '0;
  logic [N-1:0]  o_req_done;
  logic          o_req_err;
  logic [31:0]   o_rdata;
  logic [N-1:0]  o_grant;
  logic [31:0]   o_addr;
  logic [31:0]   o_wdata;
  logic [1:0]    o_rw;
  logic          o_clear_done;
  logic [31:0]   i_rdata = '0;
  logic          i_wait = 1'b0;
  logic          i_done = 1'b0;
  logic          i_invalid = 1'b0;
  logic          i_error = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  host_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_req_rw(i_req_rw),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_done(o_req_done), .o_req_err(o_req_err), .o_rdata(o_rdata), .o_grant(o_grant),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_rw(o_rw), .o_clear_done(o_clear_done),
    .i_rdata(i_rdata), .i_wait(i_wait), .i_done(i_done), .i_invalid(i_invalid), .i_error(i_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full master transaction for requester k, expected to be the winner at the next edge
  task automatic do_txn(input int k, input logic [1:0] rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic berr, input logic drop);
    logic [N-1:0] oh;
    oh = N'(1) << k;
    i_req_rw[2*k +: 2]     = rw;
    i_req_addr[32*k +: 32] = addr;
    i_req_wdata[32*k +: 32] = wdata;
    i_req[k] = 1'b1;
    tick();
    chk("grant", o_grant, oh);
    chk("issue_rw", o_rw, rw);
    chk("issue_addr", o_addr, addr);
    chk("issue_wdata", o_wdata, wdata);
    i_req_addr[32*k +: 32]  = ~addr;
    i_req_wdata[32*k +: 32] = ~wdata;
    tick();
    chk("wait_rw", o_rw, rw);
    chk("wait_addr", o_addr, addr);
    chk("wait_clear", o_clear_done, 1'b0);
    i_rdata = rdata;
    i_error = berr;
    i_done  = 1'b1;
    tick();
    i_done  = 1'b0;
    i_error = 1'b0;
    chk("done", o_req_done, oh);
    chk("err", o_req_err, berr);
    chk("rdata", o_rdata, rdata);
    chk("clear_done", o_clear_done, 1'b1);
    chk("clear_rw", o_rw, 2'b00);
    if (drop) i_req[k] = 1'b0;
    tick();
    chk("idle_grant", o_grant, '0);
    chk("idle_done", o_req_done, '0);
    chk("idle_clear", o_clear_done, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    tick();
    tick();
    chk("rst_grant", o_grant, '0);
    chk("rst_done", o_req_done, '0);
    chk("rst_err", o_req_err, 1'b0);
    chk("rst_rdata", o_rdata, '0);
    chk("rst_rw", o_rw, 2'b00);
    chk("rst_addr", o_addr, '0);
    chk("rst_wdata", o_wdata, '0);
    chk("rst_clear", o_clear_done, 1'b0);
    i_rst = 1'b0;
    tick();
    chk("idle_no_req", o_grant, '0);
    do_txn(0, 2'b01, 32'h1000_0000, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b1);
    do_txn(2, 2'b10, 32'h2000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // illegal rw=11 on requester 1: completes with error, master untouched
    i_req_rw[3:2] = 2'b11;
    i_req[1] = 1'b1;
    tick();
    chk("bad_grant", o_grant, 4'b0010);
    chk("bad_done", o_req_done, 4'b0010);
    chk("bad_err", o_req_err, 1'b1);
    chk("bad_rdata", o_rdata, '0);
    chk("bad_rw", o_rw, 2'b00);
    chk("bad_addr", o_addr, '0);
    i_req[1] = 1'b0;
    tick();
    chk("bad_idle_done", o_req_done, '0);
    chk("bad_idle_rw", o_rw, 2'b00);
    // rw=00 requester is ignored
    i_req_rw[1:0] = 2'b00;
    i_req[0] = 1'b1;
    tick();
    chk("rw00_ignored", o_grant, '0);
    i_req[0] = 1'b0;
    do_txn(3, 2'b01, 32'h3000_0000, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
    // all four from reset
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int j = 0; j < N; j++) begin
      i_req_rw[2*j +: 2] = 2'b01;
      i_req[j] = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      do_txn(FIX ? 0 : i % N, 2'b01, 32'h4000_0000 + i, 32'h5000_0000 + i, 32'h0, 1'b0, 1'b0);
    // reset during WAIT_DONE
    tick();
    chk("pre_rst_grant", o_grant, FIX ? 4'b0001 : 4'b0010);
    tick();
    chk("pre_rst_rw", o_rw, 2'b01);
    #1 i_rst = 1'b1;
    #1;
    chk("mid_rst_grant", o_grant, '0);
    chk("mid_rst_rw", o_rw, 2'b00);
    chk("mid_rst_addr", o_addr, '0);
    chk("mid_rst_done", o_req_done, '0);
    tick();
    chk("rst_hold_done", o_req_done, '0);
    chk("rst_hold_clear", o_clear_done, 1'b0);
    i_rst = 1'b0;
    do_txn(0, 2'b01, 32'h6000_0000, 32'h7000_0000, 32'h0, 1'b0, 1'b0);
    i_req[2] = 1'b0;
    i_req[3] = 1'b0;
    do_txn(FIX ? 0 : 1, 2'b10, 32'h8000_0000, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_txn(0, 2'b10, 32'h9000_0000, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/host_bus_arbiter.md
HOST_BUS_ARBITER -- requirements
Module: host_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have i_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have i_req  in  NUM_REQ  per-requester request, level, held until o_req_done.
REQ-007 SHALL have i_req_rw  in  2*NUM_REQ  per-requester op: 01 write, 10 read.
REQ-008 SHALL have i_req_addr / i_req_wdata  in  NUM_REQ*ADDR_WIDTH / NUM_REQ*DATA_WIDTH  per-requester address and write data.
REQ-009 SHALL have o_req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-010 SHALL have o_req_err  out  1  error status, valid with o_req_done.
REQ-011 SHALL have o_rdata  out  DATA_WIDTH  read data, valid with o_req_done.
REQ-012 SHALL have o_grant  out  NUM_REQ  one-hot current owner, zero when idle.
REQ-013 SHALL have master-side ports o_addr, o_wdata, o_rw(2), o_clear_done (out) and i_rdata, i_wait, i_done, i_invalid, i_error (in), matching the host bus of simple_axi_master.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> CLEAR -> IDLE.
REQ-015 IDLE: if any i_req set with legal rw, SHALL pick winner, latch its rw/addr/wdata, set o_grant, go ISSUE next edge.
REQ-016 ISSUE: SHALL drive o_rw/o_addr/o_wdata from latched values; go WAIT_DONE next edge.
REQ-017 WAIT_DONE: SHALL hold o_rw until i_done=1; then capture i_rdata, err = i_error|i_invalid, drive o_rw=00, go CLEAR.
REQ-018 CLEAR: SHALL pulse o_clear_done one cycle, pulse winner's o_req_done with o_rdata/o_req_err, clear o_grant, go IDLE.
REQ-019 Minimum grant-to-done latency SHALL be 3 cycles plus master latency; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-020 Default arbitration SHALL be round-robin: search starts at index last_winner+1, wraps at NUM_REQ-1 -> 0.
REQ-021 A requester with rw=00 SHALL be ignored; rw=11 SHALL complete in IDLE->CLEAR without touching master (o_rw stays 00), o_req_err=1, o_rdata=0.
REQ-022 Requests arriving or dropping during a grant SHALL not affect the latched transaction.
REQ-023 Latched transaction SHALL be immune to requester input changes after grant.

Reset
REQ-024 On i_rst SHALL immediately enter IDLE; o_grant, o_req_done, o_req_err, o_rdata, o_rw, o_addr, o_wdata, o_clear_done all 0.
REQ-025 Round-robin pointer SHALL reset so requester 0 has first priority.
REQ-026 Reset mid-transaction SHALL drop it with no o_req_done pulse.

Configuration
REQ-027 Macro HOST_BUS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer logic removed.
REQ-028 Macro undefined: round-robin per REQ-020.

Structure
REQ-029 Shared package SHALL hold FSM state enum and rw encodings (RW_IDLE=00, RW_WRITE=01, RW_READ=10).
REQ-030 Winner selection SHALL be sub-module rr_priority_picker (request vector + pointer -> one-hot grant, valid).

Verification
REQ-031 Single write: req0 rw=01 addr=0x1000_0000 wdata=0xCAFEBABE -> one AW/W beat with those values, o_req_done[0] pulse, err=0.
REQ-032 Single read: req2 rw=10 addr=0x2000_0000, slave returns 0xDEADBEEF -> o_rdata=0xDEADBEEF with o_req_done[2].
REQ-033 All four request simultaneously from reset -> grant order 0,1,2,3, then 0 again if still requesting.
REQ-034 req1 rw=11 -> o_req_done[1], o_req_err=1, no AXI activity, o_rw stays 00.
REQ-035 Slave BRESP=2'b10 on req3 write -> o_req_err=1 with o_req_done[3], o_clear_done pulses once.
REQ-036 i_rst asserted during WAIT_DONE -> all outputs 0 same cycle, no done pulse, next grant goes to requester 0; with HOST_BUS_ARB_FIXED_PRIO_EN, repeated req0+req1 -> req0 always wins.
